// File: rtl/fall_to_rise_fifo_if.sv
// Handshake bundle for fall_to_rise_fifo: negedge write side, posedge read side,
// occupancy status and sticky error flags.
`timescale 1ns/1ps
interface fall_to_rise_fifo_if #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 3
);
  logic                 wr_en;
  logic [WIDTH-1:0]     wr_data;
  logic                 full;
  logic                 rd_en;
  logic [WIDTH-1:0]     rd_data;
  logic                 rd_valid;
  logic                 empty;
  logic [ADDR_BITS:0]   count;
  logic                 wr_overflow;
  logic                 rd_underflow;
  logic                 err_clear;

  modport slave (
    input  wr_en, wr_data, rd_en, err_clear,
    output full, rd_data, rd_valid, empty, count, wr_overflow, rd_underflow
  );

  modport master (
    output wr_en, wr_data, rd_en, err_clear,
    input  full, rd_data, rd_valid, empty, count, wr_overflow, rd_underflow
  );
endinterface

// File: rtl/fall_to_rise_fifo.sv
// Single-clock FIFO written on the falling edge and read on the rising edge,
// giving a half-cycle handoff with no pointer synchronisation.
`timescale 1ns/1ps
module fall_to_rise_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int ADDR_BITS = 3
) (
  input  logic              clk,
  input  logic              clr,
  fall_to_rise_fifo_if.slave bus
);

  logic [ADDR_BITS:0]  r_wptr;
  logic [ADDR_BITS:0]  r_rptr;
  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [WIDTH-1:0]    r_rd_data;
  logic                r_rd_valid;
  logic                r_rd_underflow;
  logic                r_wr_overflow;
  logic                r_ovf_tag;
  logic                r_clr_tog;

  logic                w_full;
  logic                w_empty;
  logic                w_wr_ok;
  logic                w_rd_ok;
  logic                w_ovf_visible;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[ADDR_BITS-1:0] == r_rptr[ADDR_BITS-1:0]) &&
                   (r_wptr[ADDR_BITS] != r_rptr[ADDR_BITS]);
  assign w_wr_ok = clr && bus.wr_en && !w_full;
  assign w_rd_ok = bus.rd_en && !w_empty;

  // wr_overflow is set on the falling edge but cleared on the rising edge. A rising-edge
  // toggle marks a clear; the flag only shows while its tag matches the current toggle.
  assign w_ovf_visible = r_wr_overflow && (r_ovf_tag == r_clr_tog);

  always_ff @(negedge clk or negedge clr) begin
    if (!clr) begin
      r_wptr        <= '0;
      r_wr_overflow <= 1'b0;
      r_ovf_tag     <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (bus.wr_en && w_full) begin
        r_wr_overflow <= 1'b1;
        r_ovf_tag     <= r_clr_tog;
      end else if (r_ovf_tag != r_clr_tog) begin
        r_wr_overflow <= 1'b0;
        r_ovf_tag     <= r_clr_tog;
      end
    end
  end

  always_ff @(negedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wptr[ADDR_BITS-1:0]] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_rptr         <= '0;
      r_rd_data      <= '0;
      r_rd_valid     <= 1'b0;
      r_rd_underflow <= 1'b0;
      r_clr_tog      <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_ok;
      if (w_rd_ok) begin
        r_rd_data <= r_mem[r_rptr[ADDR_BITS-1:0]];
        r_rptr    <= r_rptr + 1'b1;
      end
      if (bus.err_clear) begin
        r_rd_underflow <= 1'b0;
        r_clr_tog      <= ~r_clr_tog;
      end else if (bus.rd_en && w_empty) begin
        r_rd_underflow <= 1'b1;
      end
    end
  end

  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.count        = r_wptr - r_rptr;
  assign bus.rd_data      = r_rd_data;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.wr_overflow  = w_ovf_visible;
  assign bus.rd_underflow = r_rd_underflow;

endmodule

// File: tb/tb_fall_to_rise_fifo.sv
// Directed bench for fall_to_rise_fifo: reset, handoff, fill/overflow, freed slot,
// underflow/err_clear, pointer wrap and asynchronous mid-operation reset.
`timescale 1ns/1ps
module tb_fall_to_rise_fifo;
  localparam int WIDTH     = 32;
  localparam int DEPTH     = 8;
  localparam int ADDR_BITS = 3;

  logic clk = 1'b0;
  logic clr;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fall_to_rise_fifo_if #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) bus ();

  fall_to_rise_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  task automatic test_reset();
    clr = 1'b0;
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_en = 1'b0; bus.err_clear = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    clr = 1'b1;
    #1;
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    checks++; if (bus.count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", bus.rd_valid); end
    checks++; if (bus.rd_data !== 32'h0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", bus.rd_data); end
    checks++; if (bus.wr_overflow !== 1'b0 || bus.rd_underflow !== 1'b0) begin
      failures++; $display("FAIL reset_flags got=%b%b exp=00", bus.wr_overflow, bus.rd_underflow); end
    $display("reset released: empty=%b count=%0d", bus.empty, bus.count);
  endtask

  task automatic test_handoff();
    @(posedge clk); #1;
    bus.wr_en = 1'b1; bus.wr_data = 32'hDEADBEEF; bus.rd_en = 1'b1;
    @(negedge clk); #1;
    bus.wr_en = 1'b0;
    checks++; if (bus.count !== 4'd1) begin failures++; $display("FAIL handoff_count1 got=%0d exp=1", bus.count); end
    @(posedge clk); #1;
    bus.rd_en = 1'b0;
    checks++; if (bus.rd_data !== 32'hDEADBEEF) begin failures++; $display("FAIL handoff_data got=%h exp=deadbeef", bus.rd_data); end
    checks++; if (bus.rd_valid !== 1'b1) begin failures++; $display("FAIL handoff_valid got=%b exp=1", bus.rd_valid); end
    checks++; if (bus.count !== 4'd0) begin failures++; $display("FAIL handoff_count0 got=%0d exp=0", bus.count); end
    $display("handoff: rd_data=%h rd_valid=%b", bus.rd_data, bus.rd_valid);
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      bus.wr_en = 1'b1; bus.wr_data = i;
      @(negedge clk); #1;
      bus.wr_en = 1'b0;
      $display("write %h: count=%0d full=%b ovf=%b", i, bus.count, bus.full, bus.wr_overflow);
      if (i == 8) begin
        checks++; if (bus.full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", bus.full); end
        checks++; if (bus.wr_overflow !== 1'b0) begin failures++; $display("FAIL fill_no_ovf got=%b exp=0", bus.wr_overflow); end
      end
      if (i == 9) begin
        checks++; if (bus.wr_overflow !== 1'b1) begin failures++; $display("FAIL fill_ovf got=%b exp=1", bus.wr_overflow); end
        checks++; if (bus.count !== 4'd8) begin failures++; $display("FAIL fill_count got=%0d exp=8", bus.count); end
      end
    end
    for (int i = 1; i <= 8; i++) begin
      bus.rd_en = 1'b1;
      @(posedge clk); #1;
      bus.rd_en = 1'b0;
      $display("read %0d: rd_data=%h rd_valid=%b", i, bus.rd_data, bus.rd_valid);
      checks++; if (bus.rd_data !== 32'(i) || bus.rd_valid !== 1'b1) begin
        failures++; $display("FAIL drain_data got=%h/%b exp=%h/1", bus.rd_data, bus.rd_valid, i); end
      @(negedge clk); #1;
    end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", bus.empty); end
  endtask

  task automatic test_freed_slot();
    logic [31:0] exp_q [$];
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      bus.wr_en = 1'b1; bus.wr_data = 32'h10 + 32'(i);
      @(negedge clk); #1;
      bus.wr_en = 1'b0;
    end
    checks++; if (bus.full !== 1'b1) begin failures++; $display("FAIL freed_full0 got=%b exp=1", bus.full); end
    bus.rd_en = 1'b1;
    @(posedge clk); #1;
    bus.rd_en = 1'b0;
    checks++; if (bus.rd_data !== 32'h10 || bus.full !== 1'b0) begin
      failures++; $display("FAIL freed_read got=%h/%b exp=10/0", bus.rd_data, bus.full); end
    bus.wr_en = 1'b1; bus.wr_data = 32'hAA;
    @(negedge clk); #1;
    bus.wr_en = 1'b0;
    $display("freed slot write aa: full=%b count=%0d ovf=%b", bus.full, bus.count, bus.wr_overflow);
    checks++; if (bus.full !== 1'b1 || bus.count !== 4'd8) begin
      failures++; $display("FAIL freed_refull got=%b/%0d exp=1/8", bus.full, bus.count); end
    checks++; if (bus.wr_overflow !== 1'b1) begin failures++; $display("FAIL freed_ovf_kept got=%b exp=1", bus.wr_overflow); end
    // clear at posedge, then overflow at the very next negedge must be visible
    bus.err_clear = 1'b1;
    @(posedge clk); #1;
    bus.err_clear = 1'b0;
    checks++; if (bus.wr_overflow !== 1'b0) begin failures++; $display("FAIL errclr_ovf got=%b exp=0", bus.wr_overflow); end
    bus.wr_en = 1'b1; bus.wr_data = 32'hBB;
    @(negedge clk); #1;
    bus.wr_en = 1'b0;
    checks++; if (bus.wr_overflow !== 1'b1) begin failures++; $display("FAIL ovf_after_clear got=%b exp=1", bus.wr_overflow); end
    for (int i = 1; i < 8; i++) exp_q.push_back(32'h10 + 32'(i));
    exp_q.push_back(32'hAA);
    foreach (exp_q[k]) begin
      bus.rd_en = 1'b1;
      @(posedge clk); #1;
      bus.rd_en = 1'b0;
      $display("read: rd_data=%h", bus.rd_data);
      checks++; if (bus.rd_data !== exp_q[k]) begin failures++; $display("FAIL freed_drain got=%h exp=%h", bus.rd_data, exp_q[k]); end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_underflow();
    bus.rd_en = 1'b1;
    @(posedge clk); #1;
    bus.rd_en = 1'b0;
    $display("underflow read: rd_valid=%b udf=%b rd_data=%h", bus.rd_valid, bus.rd_underflow, bus.rd_data);
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL udf_valid got=%b exp=0", bus.rd_valid); end
    checks++; if (bus.rd_underflow !== 1'b1) begin failures++; $display("FAIL udf_flag got=%b exp=1", bus.rd_underflow); end
    checks++; if (bus.rd_data !== 32'hAA) begin failures++; $display("FAIL udf_hold got=%h exp=aa", bus.rd_data); end
    bus.err_clear = 1'b1;
    @(posedge clk); #1;
    bus.err_clear = 1'b0;
    checks++; if (bus.rd_underflow !== 1'b0 || bus.wr_overflow !== 1'b0) begin
      failures++; $display("FAIL errclr_both got=%b%b exp=00", bus.rd_underflow, bus.wr_overflow); end
    bus.rd_en = 1'b1; bus.err_clear = 1'b1;
    @(posedge clk); #1;
    bus.rd_en = 1'b0; bus.err_clear = 1'b0;
    checks++; if (bus.rd_underflow !== 1'b0) begin failures++; $display("FAIL errclr_priority got=%b exp=0", bus.rd_underflow); end
  endtask

  task automatic test_wrap_reset();
    logic [31:0] q [$];
    logic [31:0] exp_d = '0;
    int  wi = 0, rissued = 0, rchecked = 0, cyc = 0;
    bit  pend = 1'b0;
    @(negedge clk); #1;
    while (rchecked < 17 && cyc < 200) begin
      @(posedge clk); #1;
      if (pend) begin
        rchecked++;
        $display("wrap read %0d: rd_data=%h exp=%h", rchecked, bus.rd_data, exp_d);
        checks++; if (bus.rd_data !== exp_d || bus.rd_valid !== 1'b1) begin
          failures++; $display("FAIL wrap_data got=%h/%b exp=%h/1", bus.rd_data, bus.rd_valid, exp_d); end
      end else begin
        checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL wrap_idle_valid got=%b exp=0", bus.rd_valid); end
      end
      checks++; if (bus.count !== 4'(q.size())) begin failures++; $display("FAIL wrap_count got=%0d exp=%0d", bus.count, q.size()); end
      pend = 1'b0;
      if (rchecked == 17) break;
      if (wi < 20) begin
        bus.wr_en = 1'b1; bus.wr_data = 32'h100 + 32'(wi);
      end
      @(negedge clk); #1;
      if (bus.wr_en) begin q.push_back(bus.wr_data); wi++; end
      bus.wr_en = 1'b0;
      if (q.size() > 0 && rissued < 17 && ((cyc % 4) != 3 || wi == 20)) begin
        bus.rd_en = 1'b1; exp_d = q.pop_front(); rissued++; pend = 1'b1;
      end else begin
        bus.rd_en = 1'b0;
      end
      cyc++;
    end
    bus.rd_en = 1'b0;
    checks++; if (cyc >= 200) begin failures++; $display("FAIL wrap_timeout got=%0d exp<200", cyc); end
    checks++; if (bus.count !== 4'd3) begin failures++; $display("FAIL wrap_final_count got=%0d exp=3", bus.count); end
    #2; clr = 1'b0; #1;
    $display("mid-op reset: count=%0d rd_valid=%b empty=%b", bus.count, bus.rd_valid, bus.empty);
    checks++; if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin
      failures++; $display("FAIL midreset_count got=%0d/%b exp=0/1", bus.count, bus.empty); end
    checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 32'h0) begin
      failures++; $display("FAIL midreset_rd got=%b/%h exp=0/0", bus.rd_valid, bus.rd_data); end
    @(posedge clk); #2;
    clr = 1'b1;
    bus.wr_en = 1'b1; bus.wr_data = 32'h55;
    @(negedge clk); #1;
    bus.wr_en = 1'b0; bus.rd_en = 1'b1;
    checks++; if (bus.count !== 4'd1) begin failures++; $display("FAIL post_reset_write got=%0d exp=1", bus.count); end
    @(posedge clk); #1;
    bus.rd_en = 1'b0;
    $display("post-reset read: rd_data=%h rd_valid=%b", bus.rd_data, bus.rd_valid);
    checks++; if (bus.rd_data !== 32'h55 || bus.rd_valid !== 1'b1) begin
      failures++; $display("FAIL post_reset_read got=%h/%b exp=55/1", bus.rd_data, bus.rd_valid); end
  endtask

  initial begin
    test_reset();
    test_handoff();
    test_fill_overflow();
    test_freed_slot();
    test_underflow();
    test_wrap_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fall_to_rise_fifo.md
Name: fall_to_rise_fifo

Overview:
- Buffer that carries words from falling-edge producer logic to rising-edge consumer logic within one clock.
- Producers are negedge-clocked enable/clear flop stages, such as memory/regfile write paths and the plotter command staging registers.
- Write side samples on the falling edge of clk; read side samples on the rising edge of clk.
- Because both pointers live in one clock, no synchroniser is needed, and handoff latency is half a cycle.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 8, number of entries; must be a power of two, at least 2.
- ADDR_BITS, 3, log2(DEPTH); must match DEPTH.

Ports:
- clk  input  1  single clock; write logic on negedge, read logic on posedge.
- clr  input  1  asynchronous, active-low reset.
- wr_en  input  1  write request, sampled at falling edge of clk.
- wr_data  input  WIDTH  write data, sampled at falling edge.
- full  output  1  combinational; FIFO holds DEPTH entries.
- rd_en  input  1  read request, sampled at rising edge of clk.
- rd_data  output  WIDTH  registered read data, updated at rising edge.
- rd_valid  output  1  registered; high for one cycle after an accepted read.
- empty  output  1  combinational; FIFO holds 0 entries.
- count  output  ADDR_BITS+1  combinational occupancy, 0..DEPTH.
- wr_overflow  output  1  sticky; set when a write is attempted while full.
- rd_underflow  output  1  sticky; set when a read is attempted while empty.
- err_clear  input  1  sampled at rising edge; clears both sticky flags.

Behaviour:
- Reset is asynchronous and active-low on clr. While clr=0, and immediately on assertion:
  - wptr=0, rptr=0, rd_data=0, rd_valid=0, wr_overflow=0, rd_underflow=0.
  - This gives empty=1, full=0, count=0.
  - Storage array is not cleared.
- Pointers are ADDR_BITS+1 bits wide; the extra bit is a wrap bit.
  - count = wptr - rptr, modulo 2^(ADDR_BITS+1).
  - empty = (wptr == rptr).
  - full = (low bits equal) and (wrap bits differ).
- Write, at falling edge of clk:
  - If wr_en=1 and full=0: mem[wptr low bits] <= wr_data; wptr <= wptr+1.
  - If wr_en=1 and full=1: data dropped, wptr unchanged, wr_overflow <= 1.
- Read, at rising edge of clk:
  - If rd_en=1 and empty=0: rd_data <= mem[rptr low bits]; rptr <= rptr+1; rd_valid <= 1.
  - If rd_en=1 and empty=1: rd_data holds, rd_valid <= 0, rd_underflow <= 1.
  - If rd_en=0: rd_valid <= 0, rd_data holds.
- Latency:
  - A word written at the falling edge of cycle N is readable at the rising edge that ends cycle N (half cycle).
  - It appears on rd_data/rd_valid just after that edge.
- Freed slot: a read at a rising edge frees its slot, so a write at the very next falling edge is accepted even if the FIFO was full.
- Writes and reads never share an edge, so there is no same-edge collision case. Occupancy changes by at most 1 per edge.
- Pointer wrap: after DEPTH accepted writes the low bits return to 0 and the wrap bit toggles; ordering is preserved across the wrap.
- err_clear:
  - err_clear=1 at a rising edge clears rd_underflow and takes priority over a same-edge underflow set.
  - A wr_overflow set at the following falling edge is not masked.
- Reset mid-operation: all state returns to reset values immediately, buffered data is discarded, and rd_valid drops without waiting for a clock edge.
- Releasing clr near a clock edge: the first legal write is at the first falling edge after clr rises; the first legal read is at the first rising edge.

Test Plan:
- Reset then idle: clr=0 for 2 cycles, then release. Required: empty=1, full=0, count=0, rd_valid=0, rd_data=0, both sticky flags 0.
- Half-cycle handoff: write 0xDEADBEEF at negedge with rd_en held high. Required: rd_data=0xDEADBEEF and rd_valid=1 after the following posedge; count returns 1→0.
- Fill and overflow (DEPTH=8): write 0x01..0x09 on consecutive negedges with no reads. Required: full=1 after the 8th write, 0x09 dropped, wr_overflow=1, count=8.
  - Then read 8 times. Required: outputs 0x01..0x08 in order, then empty=1.
- Full with freed slot: at full, read at posedge, then write 0xAA at the next negedge. Required: write accepted, full=1 again, wr_overflow unchanged.
- Underflow and clear: rd_en=1 while empty. Required: rd_valid=0, rd_underflow=1.
  - Then err_clear=1 for one cycle. Required: rd_underflow=0.
- Wrap and mid-op reset: stream 20 words 0x100..0x113 with interleaved reads. Required: output order exact across two pointer wraps.
  - Then assert clr with count=3. Required: count=0 and rd_valid=0 immediately, before any clock edge.
